// File: rtl/can_frame_rx.sv
// CAN-style frame receiver (no bit stuffing).
// Fields: SOF, 11-bit ID, 8-bit CTRL, 32-bit DATA, 15-bit CRC, ACK slot, 1 EOF bit.
// Filters the ID, checks CRC-15 and drives the ACK slot on txd.
// Passes accepted frames to a FIFO, or reports a CRC, form or overflow error.
module can_frame_rx #(
    parameter logic [10:0] ACCEPT_ID   = 11'h550,
    parameter logic [10:0] ACCEPT_MASK = 11'h7FF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        bit_en,
    input  logic        rxd,
    input  logic        fifo_full,
    output logic        txd,
    output logic        write_fifo,
    output logic [10:0] rx_id,
    output logic [7:0]  rx_ctrl,
    output logic [31:0] rx_data,
    output logic        crc_err,
    output logic        form_err,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ID   = 3'd1,
        S_CTRL = 3'd2,
        S_DATA = 3'd3,
        S_CRC  = 3'd4,
        S_ACK  = 3'd5,
        S_EOF  = 3'd6
    } state_e;

    state_e      state_r;
    state_e      state_nxt_s;
    logic [5:0]  cnt_r;
    logic [14:0] crc_r;
    logic [10:0] id_sh_r;
    logic [7:0]  ctrl_sh_r;
    logic [31:0] data_sh_r;
    // Holds 14 received CRC bits; the 15th bit goes straight into the compare.
    logic [13:0] rcrc_sh_r;
    logic        id_ok_r;
    logic        crc_ok_r;

    logic        field_last_s;
    logic [10:0] id_shift_s;
    logic [14:0] rcrc_shift_s;
    logic        id_match_s;
    logic        crc_match_s;

    // One CRC-15 step: polynomial 0x4599, processing the message MSB first.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    // Shadow values that include the bit being sampled now, used for the end-of-field checks.
    always_comb begin
        id_shift_s   = {id_sh_r[9:0], rxd};
        rcrc_shift_s = {rcrc_sh_r, rxd};
        id_match_s   = (((id_shift_s ^ ACCEPT_ID) & ACCEPT_MASK) == 11'h000);
        crc_match_s  = (rcrc_shift_s == crc_r);
    end

    // Detect the last bit of the current field and choose the next state.
    always_comb begin
        state_nxt_s  = state_r;
        field_last_s = 1'b0;
        case (state_r)
            S_IDLE:  field_last_s = ~rxd;
            S_ID:    field_last_s = (cnt_r == 6'd10);
            S_CTRL:  field_last_s = (cnt_r == 6'd7);
            S_DATA:  field_last_s = (cnt_r == 6'd31);
            S_CRC:   field_last_s = (cnt_r == 6'd14);
            S_ACK:   field_last_s = 1'b1;
            S_EOF:   field_last_s = 1'b1;
            default: field_last_s = 1'b1;
        endcase
        if (bit_en && field_last_s) begin
            case (state_r)
                S_IDLE:  state_nxt_s = S_ID;
                S_ID:    state_nxt_s = S_CTRL;
                S_CTRL:  state_nxt_s = S_DATA;
                S_DATA:  state_nxt_s = S_CRC;
                S_CRC:   state_nxt_s = S_ACK;
                S_ACK:   state_nxt_s = S_EOF;
                S_EOF:   state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bit counter, CRC, shadows, ACK drive and one-cycle result pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r      <= 6'd0;
            crc_r      <= 15'h0000;
            id_sh_r    <= 11'h000;
            ctrl_sh_r  <= 8'h00;
            data_sh_r  <= 32'h0000_0000;
            rcrc_sh_r  <= 14'h0000;
            id_ok_r    <= 1'b0;
            crc_ok_r   <= 1'b0;
            txd        <= 1'b1;
            write_fifo <= 1'b0;
            crc_err    <= 1'b0;
            form_err   <= 1'b0;
            overflow   <= 1'b0;
            rx_id      <= 11'h000;
            rx_ctrl    <= 8'h00;
            rx_data    <= 32'h0000_0000;
        end else begin
            write_fifo <= 1'b0;
            crc_err    <= 1'b0;
            form_err   <= 1'b0;
            overflow   <= 1'b0;
            if (bit_en) begin
                if ((state_r == S_IDLE) || field_last_s) begin
                    cnt_r <= 6'd0;
                end else begin
                    cnt_r <= cnt_r + 6'd1;
                end
                case (state_r)
                    S_IDLE: begin
                        if (!rxd) begin
                            crc_r <= crc15_step(15'h0000, 1'b0);
                        end
                    end
                    S_ID: begin
                        id_sh_r <= id_shift_s;
                        crc_r   <= crc15_step(crc_r, rxd);
                        if (field_last_s) begin
                            id_ok_r <= id_match_s;
                        end
                    end
                    S_CTRL: begin
                        ctrl_sh_r <= {ctrl_sh_r[6:0], rxd};
                        crc_r     <= crc15_step(crc_r, rxd);
                    end
                    S_DATA: begin
                        data_sh_r <= {data_sh_r[30:0], rxd};
                        crc_r     <= crc15_step(crc_r, rxd);
                    end
                    S_CRC: begin
                        rcrc_sh_r <= rcrc_shift_s[13:0];
                        if (field_last_s) begin
                            crc_ok_r <= crc_match_s;
                            txd      <= ~(id_ok_r && crc_match_s);
                        end
                    end
                    S_ACK: begin
                        txd <= 1'b1;
                    end
                    S_EOF: begin
                        if (!rxd) begin
                            form_err <= 1'b1;
                        end else if (id_ok_r && crc_ok_r) begin
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                write_fifo <= 1'b1;
                                rx_id      <= id_sh_r;
                                rx_ctrl    <= ctrl_sh_r;
                                rx_data    <= data_sh_r;
                            end
                        end
                        if (id_ok_r && !crc_ok_r) begin
                            crc_err <= 1'b1;
                        end
                    end
                    default: begin
                        txd <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_frame_rx.sv
// Scoreboard bench for can_frame_rx: a second instance is built with a zero
// acceptance mask and is only clocked with bit strobes during the mask frame.
module tb_can_frame_rx;

    typedef enum logic [1:0] {EV_WRITE = 2'd0, EV_CRC = 2'd1, EV_FORM = 2'd2, EV_OVF = 2'd3} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [10:0] id;
        logic [7:0]  ctrl;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        n_rst, bit_en, rxd, fifo_full, sel_m;
    logic        txd, write_fifo, crc_err, form_err, overflow;
    logic [10:0] rx_id;
    logic [7:0]  rx_ctrl;
    logic [31:0] rx_data;
    logic        txd_m, write_fifo_m, crc_err_m, form_err_m, overflow_m;
    logic [10:0] rx_id_m;
    logic [7:0]  rx_ctrl_m;
    logic [31:0] rx_data_m;
    logic        bit_en_m;

    ev_t         exp_q[$];
    ev_t         exp_m_q[$];
    int          errors = 0;
    int          checks = 0;
    int          ack_cnt = 0;
    int          ack_m_cnt = 0;
    logic [10:0] m_id;
    logic [7:0]  m_ctrl;
    logic [31:0] m_data;

    assign bit_en_m = bit_en & sel_m;

    can_frame_rx u_dut (
        .clk(clk), .n_rst(n_rst), .bit_en(bit_en), .rxd(rxd), .fifo_full(fifo_full),
        .txd(txd), .write_fifo(write_fifo), .rx_id(rx_id), .rx_ctrl(rx_ctrl), .rx_data(rx_data),
        .crc_err(crc_err), .form_err(form_err), .overflow(overflow)
    );

    can_frame_rx #(.ACCEPT_ID(11'h550), .ACCEPT_MASK(11'h000)) u_dut_m (
        .clk(clk), .n_rst(n_rst), .bit_en(bit_en_m), .rxd(rxd), .fifo_full(fifo_full),
        .txd(txd_m), .write_fifo(write_fifo_m), .rx_id(rx_id_m), .rx_ctrl(rx_ctrl_m), .rx_data(rx_data_m),
        .crc_err(crc_err_m), .form_err(form_err_m), .overflow(overflow_m)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Pop and compare one expected event for an observed output pulse.
    task automatic take(input int dut, input ev_kind_e k, input logic [10:0] id,
                        input logic [7:0] ctrl, input logic [31:0] data);
        ev_t  e;
        logic got;
        got = 1'b0;
        e   = '0;
        checks++;
        if (dut == 0) begin
            if (exp_q.size() > 0) begin e = exp_q.pop_front(); got = 1'b1; end
        end else begin
            if (exp_m_q.size() > 0) begin e = exp_m_q.pop_front(); got = 1'b1; end
        end
        if (!got) begin
            errors++;
            $display("FAIL unexpected_event dut=%0d actual=%s required=none", dut, k.name());
        end else if (e.kind != k) begin
            errors++;
            $display("FAIL event_kind dut=%0d actual=%s required=%s", dut, k.name(), e.kind.name());
        end else if ((k == EV_WRITE) && ({id, ctrl, data} != {e.id, e.ctrl, e.data})) begin
            errors++;
            $display("FAIL write_payload dut=%0d actual=%h/%h/%h required=%h/%h/%h",
                     dut, id, ctrl, data, e.id, e.ctrl, e.data);
        end
    endtask

    // Monitor: count ACK cycles and match every result pulse against the scoreboard.
    always @(negedge clk) begin
        if (n_rst) begin
            if (txd == 1'b0)   ack_cnt++;
            if (txd_m == 1'b0) ack_m_cnt++;
            if (write_fifo)   take(0, EV_WRITE, rx_id, rx_ctrl, rx_data);
            if (crc_err)      take(0, EV_CRC, 11'h0, 8'h0, 32'h0);
            if (form_err)     take(0, EV_FORM, 11'h0, 8'h0, 32'h0);
            if (overflow)     take(0, EV_OVF, 11'h0, 8'h0, 32'h0);
            if (write_fifo_m) take(1, EV_WRITE, rx_id_m, rx_ctrl_m, rx_data_m);
            if (crc_err_m)    take(1, EV_CRC, 11'h0, 8'h0, 32'h0);
            if (form_err_m)   take(1, EV_FORM, 11'h0, 8'h0, 32'h0);
            if (overflow_m)   take(1, EV_OVF, 11'h0, 8'h0, 32'h0);
        end
    end

    function automatic logic [14:0] crc_ref(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_ref = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    // Build a 69-bit frame: SOF, ID, CTRL, DATA, CRC (xor'd with a fault mask), ACK=1, EOF.
    function automatic logic [68:0] mk_frame(input logic [10:0] id, input logic [7:0] ctrl,
                                             input logic [31:0] data, input logic [14:0] crc_x,
                                             input logic eof);
        logic [68:0] f;
        logic [14:0] c;
        f = {1'b0, id, ctrl, data, 15'h0000, 1'b1, eof};
        c = 15'h0000;
        for (int i = 68; i >= 17; i--) c = crc_ref(c, f[i]);
        f[16:2] = c ^ crc_x;
        mk_frame = f;
    endfunction

    task automatic send_bit(input logic b, input int div);
        rxd = b;
        for (int k = 0; k < div; k++) begin
            bit_en = (k == div - 1);
            @(posedge clk);
            #1;
        end
        bit_en = 1'b0;
    endtask

    task automatic send_bits(input logic [68:0] f, input int count, input int div);
        for (int i = 68; i > 68 - count; i--) send_bit(f[i], div);
    endtask

    task automatic push(input ev_kind_e k, input logic [10:0] id, input logic [7:0] ctrl,
                        input logic [31:0] data);
        exp_q.push_back({k, id, ctrl, data});
        if (k == EV_WRITE) begin
            m_id = id; m_ctrl = ctrl; m_data = data;
        end
    endtask

    task automatic run_frame(input string nm, input logic [10:0] id, input logic [7:0] ctrl,
                             input logic [31:0] data, input logic [14:0] crc_x, input logic eof,
                             input int div, input int exp_ack);
        ack_cnt   = 0;
        ack_m_cnt = 0;
        send_bits(mk_frame(id, ctrl, data, crc_x, eof), 69, div);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_ack_cycles"}, 64'(ack_cnt), 64'(exp_ack));
        chk({nm, "_rx_regs"}, {21'h0, rx_id, rx_ctrl, rx_data}, {21'h0, m_id, m_ctrl, m_data});
        chk({nm, "_txd_idle"}, 64'(txd), 64'd1);
    endtask

    initial begin
        n_rst = 1'b0; rxd = 1'b1; bit_en = 1'b0; fifo_full = 1'b0; sel_m = 1'b0;
        m_id = 11'h000; m_ctrl = 8'h00; m_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_txd", 64'(txd), 64'd1);
        chk("reset_rx", {21'h0, rx_id, rx_ctrl, rx_data}, 64'd0);
        chk("reset_pulses", {60'h0, write_fifo, crc_err, form_err, overflow}, 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);

        push(EV_WRITE, 11'h550, 8'h20, 32'hDEADBEEF);
        run_frame("good", 11'h550, 8'h20, 32'hDEADBEEF, 15'h0000, 1'b1, 1, 1);

        push(EV_WRITE, 11'h550, 8'h5A, 32'h0000_0000);
        run_frame("good_zero", 11'h550, 8'h5A, 32'h0000_0000, 15'h0000, 1'b1, 1, 1);

        push(EV_CRC, 11'h0, 8'h0, 32'h0);
        run_frame("crc_bad", 11'h550, 8'h20, 32'hDEADBEEF, 15'h0001, 1'b1, 1, 0);

        sel_m = 1'b1;
        exp_m_q.push_back({EV_WRITE, 11'h123, 8'h20, 32'hDEADBEEF});
        run_frame("id_reject", 11'h123, 8'h20, 32'hDEADBEEF, 15'h0000, 1'b1, 1, 0);
        sel_m = 1'b0;
        chk("mask_pending", 64'(exp_m_q.size()), 64'd0);
        chk("mask_ack_cycles", 64'(ack_m_cnt), 64'd1);
        chk("mask_rx_regs", {21'h0, rx_id_m, rx_ctrl_m, rx_data_m}, {21'h0, 11'h123, 8'h20, 32'hDEADBEEF});

        push(EV_FORM, 11'h0, 8'h0, 32'h0);
        run_frame("eof_dominant", 11'h550, 8'h20, 32'hDEADBEEF, 15'h0000, 1'b0, 1, 1);

        fifo_full = 1'b1;
        push(EV_OVF, 11'h0, 8'h0, 32'h0);
        run_frame("fifo_full", 11'h550, 8'h33, 32'h0102_0304, 15'h0000, 1'b1, 1, 1);
        fifo_full = 1'b0;

        push(EV_WRITE, 11'h550, 8'h20, 32'hDEADBEEF);
        run_frame("slow_bits", 11'h550, 8'h20, 32'hDEADBEEF, 15'h0000, 1'b1, 4, 4);

        send_bits(mk_frame(11'h550, 8'h77, 32'hA5A5_A5A5, 15'h0000, 1'b1), 36, 1);
        #2;
        n_rst = 1'b0;
        m_id = 11'h000; m_ctrl = 8'h00; m_data = 32'h0;
        @(negedge clk);
        chk("midreset_rx", {21'h0, rx_id, rx_ctrl, rx_data}, 64'd0);
        chk("midreset_txd", 64'(txd), 64'd1);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int i = 0; i < 80; i++) send_bit(1'b1, 1);
        chk("midreset_quiet", 64'(exp_q.size()), 64'd0);
        chk("midreset_rx_idle", {21'h0, rx_id, rx_ctrl, rx_data}, 64'd0);

        push(EV_WRITE, 11'h550, 8'h08, 32'h1234_5678);
        run_frame("after_reset", 11'h550, 8'h08, 32'h1234_5678, 15'h0000, 1'b1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
